// File: rtl/dft_scan_ctrl.sv
// Scan-test sequencer: loads stimulus into WIDTH parallel scan chains, pulses capture,
// and streams the previous pattern's response out while the next pattern loads.
module dft_scan_ctrl #(
    parameter int CHAIN_LEN = 8,
    parameter int WIDTH     = 5,
    parameter int PAT_W     = 8
) (
    input  logic             refclk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] num_patterns,
    input  logic             abort,
    input  logic [WIDTH-1:0] si_data,
    input  logic             si_valid,
    output logic             si_ready,
    input  logic [WIDTH-1:0] chain_out,
    output logic [WIDTH-1:0] scan_in,
    output logic             scan_en,
    output logic             shift_en,
    output logic             capture_en,
    output logic [WIDTH-1:0] so_data,
    output logic             so_valid,
    output logic             busy,
    output logic             done,
    output logic [PAT_W-1:0] pat_cnt
);

    localparam int CNT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_CAPTURE,
        S_UNLOAD,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] beat_cnt;
    logic [PAT_W-1:0] num_lat;
    logic             have_resp;
    logic             beat;
    logic             last_beat;
    logic             last_pat;
    logic             start_ok;

    assign si_ready = (state == S_SHIFT);
    assign busy     = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        start_ok  = 1'b0;
        beat      = (state == S_SHIFT) && si_valid;
        last_beat = (beat_cnt == LAST_BEAT);
        last_pat  = ((pat_cnt + PAT_W'(1)) == num_lat);
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    start_ok  = 1'b1;
                    state_nxt = (num_patterns == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT:   if (beat && last_beat) state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = last_pat ? S_UNLOAD : S_SHIFT;
            S_UNLOAD:  if (last_beat) state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
        if (abort && (state != S_IDLE)) state_nxt = S_IDLE;
    end

    // Strobes are registered one cycle behind the state decision; abort kills them at once.
    always_ff @(posedge refclk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            scan_in    <= '0;
            scan_en    <= 1'b0;
            shift_en   <= 1'b0;
            capture_en <= 1'b0;
            so_data    <= '0;
            so_valid   <= 1'b0;
            done       <= 1'b0;
            pat_cnt    <= '0;
            num_lat    <= '0;
            beat_cnt   <= '0;
            have_resp  <= 1'b0;
        end else begin
            state      <= state_nxt;
            scan_en    <= (state_nxt == S_SHIFT) || (state_nxt == S_UNLOAD);
            shift_en   <= !abort && (beat || (state == S_UNLOAD));
            capture_en <= !abort && (state == S_CAPTURE);
            so_valid   <= !abort && shift_en && have_resp;
            done       <= !abort && (state == S_DONE);

            if (beat) begin
                scan_in <= si_data;
            end else if (state == S_UNLOAD) begin
                scan_in <= '0;
            end

            // The tail seen while shift_en is high is the pre-shift response bit.
            if (shift_en && have_resp) so_data <= chain_out;

            if (start_ok) begin
                num_lat   <= num_patterns;
                pat_cnt   <= '0;
                beat_cnt  <= '0;
                have_resp <= 1'b0;
            end

            if (!abort) begin
                case (state)
                    S_SHIFT: begin
                        if (beat && !last_beat) beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                    S_CAPTURE: begin
                        pat_cnt   <= pat_cnt + PAT_W'(1);
                        have_resp <= 1'b1;
                        beat_cnt  <= '0;
                    end
                    S_UNLOAD: begin
                        if (!last_beat) beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
